// File: rtl/mips_ifetch_seq.sv
// -----------------------------------------------------------------------------
// mips_ifetch_seq
//   Instruction-fetch sequencer for the multicycle MIPS core. The unit builds
//   each instruction from IBYTES byte beats over the 8-bit memory bus, which
//   uses a req/ack handshake. It then hands the instruction and its PC to the
//   control FSM over a valid/ready handshake. A redirect flushes the fetch and
//   restarts it at a new aligned address.
//
//   Optional build macro: MIPS_IFETCH_BIG_ENDIAN_EN
//     When defined, the first fetched byte lands in the MSB lane of instr.
//     When undefined, the first fetched byte lands in the LSB lane
//     (little-endian). Addresses, beat order and timing are the same in both
//     builds.
//
// Parameters
//   AW        address / PC width (8..32)
//   IBYTES    bytes per instruction, power of two (2..8)
//   RESET_PC  PC loaded on reset (IBYTES-aligned)
//
// Ports
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   mem_req       byte-read request (high while fetching)
//   mem_addr      byte address of the current beat (pc + beat)
//   mem_ack       beat completes on mem_req && mem_ack
//   mem_rdata     read byte, captured on a completing beat
//   instr         assembled instruction, stable while instr_valid
//   instr_pc      address of the first byte of instr
//   instr_valid   instruction available
//   instr_ready   consumer accepts on instr_valid && instr_ready
//   redirect      flush and restart at redirect_pc (highest priority)
//   redirect_pc   new fetch address, low log2(IBYTES) bits ignored
//   busy          high while fetching
// -----------------------------------------------------------------------------
module mips_ifetch_seq #(
    parameter int              AW       = 8,
    parameter int              IBYTES   = 4,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                mem_req,
    output logic [AW-1:0]       mem_addr,
    input  logic                mem_ack,
    input  logic [7:0]          mem_rdata,
    output logic [8*IBYTES-1:0] instr,
    output logic [AW-1:0]       instr_pc,
    output logic                instr_valid,
    input  logic                instr_ready,
    input  logic                redirect,
    input  logic [AW-1:0]       redirect_pc,
    output logic                busy
);

    localparam int            BW         = (IBYTES > 1) ? $clog2(IBYTES) : 1;
    localparam logic [BW-1:0] LAST_BEAT  = BW'(IBYTES - 1);
    localparam logic [AW-1:0] ALIGN_MASK = ~AW'(IBYTES - 1);
    localparam logic [AW-1:0] PC_STEP    = AW'(IBYTES);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t        state;
    logic [AW-1:0] pc;
    logic [BW-1:0] beat;
    logic [BW-1:0] lane;

    // The byte lane that receives the current beat.
`ifdef MIPS_IFETCH_BIG_ENDIAN_EN
    assign lane = LAST_BEAT - beat;
`else
    assign lane = beat;
`endif

    // The request and the address come straight from registered state. No
    // memory read has a side effect, so mem_req may drop without an ack
    // (for example on a redirect).
    assign mem_req  = (state == FETCH);
    assign busy     = (state == FETCH);
    assign mem_addr = pc + AW'(beat);

    // NOTE: all state is updated with non-blocking assignments so that every
    // register samples the values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            beat        <= '0;
            // NOTE: the instruction register is reset as well. Partial lanes
            // must read as zero as soon as reset is asserted, not merely be
            // treated as don't-care.
            instr       <= '0;
            instr_pc    <= RESET_PC;
            instr_valid <= 1'b0;
        end else if (redirect) begin
            // A redirect overrides everything. It discards any beat that
            // completes in this cycle, and it squashes an instruction that is
            // being accepted in the same cycle.
            state       <= FETCH;
            pc          <= redirect_pc & ALIGN_MASK;
            beat        <= '0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ack) begin
                        instr[8*lane +: 8] <= mem_rdata;
                        if (beat == LAST_BEAT) begin
                            beat        <= '0;
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                            state       <= HOLD;
                        end else begin
                            beat <= beat + BW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        pc          <= pc + PC_STEP;
                        state       <= FETCH;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_ifetch_seq.sv
// -----------------------------------------------------------------------------
// tb_mips_ifetch_seq
//   Self-checking bench for mips_ifetch_seq (AW=8, IBYTES=4, RESET_PC=0).
//   A transaction-level model keeps the fetch address, the queue of bytes
//   received so far and the presented instruction. One compare process
//   checks the DUT against this model shortly after every rising edge. A
//   directed sequence pins the model with literal values, and a randomized
//   phase follows.
// -----------------------------------------------------------------------------
module tb_mips_ifetch_seq;

    localparam int          AW       = 8;
    localparam int          IBYTES   = 4;
    localparam logic [7:0]  RESET_PC = 8'h00;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                mem_req;
    logic [AW-1:0]       mem_addr;
    logic                mem_ack;
    logic [7:0]          mem_rdata;
    logic [8*IBYTES-1:0] instr;
    logic [AW-1:0]       instr_pc;
    logic                instr_valid;
    logic                instr_ready;
    logic                redirect;
    logic [AW-1:0]       redirect_pc;
    logic                busy;

    logic [7:0] mem [256];
    assign mem_rdata = mem[mem_addr];

    always #5 clk = ~clk;

    mips_ifetch_seq #(.AW(AW), .IBYTES(IBYTES), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .busy(busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  m_pc;
    logic [7:0]  m_bytes[$];
    logic        m_valid;
    logic [31:0] m_instr;
    logic [7:0]  m_ipc;

    function automatic logic [31:0] pack(input logic [7:0] b[$]);
        logic [31:0] v = '0;
        for (int k = 0; k < IBYTES; k++) begin
`ifdef MIPS_IFETCH_BIG_ENDIAN_EN
            v[8*(IBYTES-1-k) +: 8] = b[k];
`else
            v[8*k +: 8] = b[k];
`endif
        end
        return v;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pc    = RESET_PC;
            m_bytes.delete();
            m_valid = 1'b0;
            m_instr = '0;
            m_ipc   = RESET_PC;
        end else if (redirect) begin
            m_pc    = redirect_pc & 8'hFC;
            m_bytes.delete();
            m_valid = 1'b0;
        end else if (!m_valid) begin
            if (mem_ack) begin
                m_bytes.push_back(mem[8'(m_pc + 8'(m_bytes.size()))]);
                if (m_bytes.size() == IBYTES) begin
                    m_instr = pack(m_bytes);
                    m_ipc   = m_pc;
                    m_valid = 1'b1;
                    m_bytes.delete();
                end
            end
        end else if (instr_ready) begin
            m_valid = 1'b0;
            m_pc    = m_pc + 8'(IBYTES);
        end
        #1;
        check("mem_req", mem_req, !m_valid);
        check("busy", busy, !m_valid);
        check("instr_valid", instr_valid, m_valid);
        if (!m_valid)
            check("mem_addr", mem_addr, 8'(m_pc + 8'(m_bytes.size())));
        if (m_valid) begin
            check("instr", instr, m_instr);
            check("instr_pc", instr_pc, m_ipc);
        end
        if (!rst_n)
            check("instr_in_reset", instr, 32'h0);
    end

    // ---------------- stimulus ----------------
`ifdef MIPS_IFETCH_BIG_ENDIAN_EN
    localparam logic [31:0] FIRST_INSTR = 32'h20000102;
`else
    localparam logic [31:0] FIRST_INSTR = 32'h02010020;
`endif

    logic [31:0] held;
    logic [7:0]  exp_addr [7] = '{8'h04, 8'h05, 8'h05, 8'h05, 8'h06, 8'h07, 8'h07};
    logic        ack_pat  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h20; mem[1] = 8'h00; mem[2] = 8'h01; mem[3] = 8'h02;
        rst_n = 1'b0; mem_ack = 1'b1; instr_ready = 1'b0;
        redirect = 1'b0; redirect_pc = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, RESET_PC);
        check("rst_mem_req", mem_req, 1'b1);
        check("rst_busy", busy, 1'b1);

        // Test 1: basic fetch with mem_ack tied high
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("t1_addr", mem_addr, 8'(i));
            @(negedge clk);
        end
        check("t1_valid", instr_valid, 1'b1);
        check("t1_instr", instr, FIRST_INSTR);
        check("t1_pc", instr_pc, 8'h00);

        // Test 2: stall in HOLD, then accept
        held = instr;
        for (int i = 0; i < 5; i++) begin
            check("t2_req", mem_req, 1'b0);
            check("t2_valid", instr_valid, 1'b1);
            check("t2_stable", instr, held);
            @(negedge clk);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        check("t2_next_addr", mem_addr, 8'h04);
        check("t2_next_req", mem_req, 1'b1);

        // Test 3: memory wait states
        for (int i = 0; i < 7; i++) begin
            check("t3_addr", mem_addr, exp_addr[i]);
            mem_ack = ack_pat[i];
            @(negedge clk);
        end
        mem_ack = 1'b1;
        check("t3_valid", instr_valid, 1'b1);
        check("t3_pc", instr_pc, 8'h04);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;

        // Test 4: redirect after the second beat
        check("t4_addr0", mem_addr, 8'h08);
        repeat (2) @(negedge clk);
        check("t4_addr2", mem_addr, 8'h0A);
        redirect = 1'b1; redirect_pc = 8'h13;
        @(negedge clk);
        redirect = 1'b0;
        check("t4_redir_addr", mem_addr, 8'h10);
        check("t4_redir_valid", instr_valid, 1'b0);
        repeat (4) @(negedge clk);
        check("t4_valid", instr_valid, 1'b1);
        check("t4_pc", instr_pc, 8'h10);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;

        // Test 5: PC wrap, then redirect together with ready
        redirect = 1'b1; redirect_pc = 8'hFC;
        @(negedge clk);
        redirect = 1'b0;
        check("t5_addr_fc", mem_addr, 8'hFC);
        repeat (4) @(negedge clk);
        check("t5_valid_fc", instr_valid, 1'b1);
        check("t5_pc_fc", instr_pc, 8'hFC);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        check("t5_wrap_addr", mem_addr, 8'h00);
        repeat (4) @(negedge clk);
        check("t5_valid_0", instr_valid, 1'b1);
        check("t5_instr_0", instr, FIRST_INSTR);
        redirect = 1'b1; redirect_pc = 8'h41; instr_ready = 1'b1;
        @(negedge clk);
        redirect = 1'b0; instr_ready = 1'b0;
        check("t5_squash_valid", instr_valid, 1'b0);
        check("t5_squash_addr", mem_addr, 8'h40);

        // Test 6: asynchronous reset in the middle of a fetch
        repeat (2) @(negedge clk);
        check("t6_addr_beat2", mem_addr, 8'h42);
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", instr_valid, 1'b0);
        check("t6_async_instr", instr, 32'h0);
        check("t6_async_addr", mem_addr, RESET_PC);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t6_restart_addr", mem_addr, RESET_PC);
        @(negedge clk);
        repeat (3) @(negedge clk);
        check("t6_valid", instr_valid, 1'b1);
        check("t6_instr", instr, FIRST_INSTR);
        check("t6_pc", instr_pc, RESET_PC);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;

        // Randomized phase; the model checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            mem_ack     = ($urandom_range(0, 3) != 0);
            instr_ready = ($urandom_range(0, 2) == 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = 8'($urandom);
            rst_n       = ($urandom_range(0, 199) != 0);
            @(negedge clk);
        end
        rst_n = 1'b1; redirect = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
